shift_rgst: RTL and testbench

SHIFT_RGST -- requirements
Module: shift_rgst

---
 rtl/shift_rgst.sv | 130 +++++++++++++
 tb/tb_shift_rgst.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_rgst.sv
// shift_rgst: loadable shift register with a multi-cycle shift sequencer.
// A start request latches direction, arithmetic/rotate mode and a step count
// clamped to WIDTH. The sequencer then performs one 1-bit step per clock and
// ends with a single-cycle done pulse.
// Optional feature: define SHIFT_RGST_ROTATE_EN to enable rotate mode (rot input).
module shift_rgst #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic             arith,
    input  logic             sin,
    input  logic [CW-1:0]    amt,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    eff;
    logic             dir_r, arith_r;
    logic             fill_l, fill_r;
    logic [WIDTH-1:0] step_q;
    logic             step_out;
    logic             accept;

`ifdef SHIFT_RGST_ROTATE_EN
    logic             rot_r;
`else
    // rot has no function in this build; tie it off so no logic hangs on it
    logic             unused_rot;
    assign unused_rot = rot;
`endif

    // New requests are only accepted outside SHIFT; ld wins over start
    assign accept = (state != SHIFT) && !clr && !ld && start;

    // Clamp the requested step count to the register width
    always_comb begin
        eff = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;
    end

    // One-bit step of the current register contents using latched modes
    always_comb begin
        fill_l = sin;
        fill_r = arith_r ? q[WIDTH-1] : sin;
`ifdef SHIFT_RGST_ROTATE_EN
        if (rot_r) begin
            fill_l = q[WIDTH-1];
            fill_r = q[0];
        end
`endif
        if (dir_r) begin
            step_q   = {fill_r, q[WIDTH-1:1]};
            step_out = q[0];
        end else begin
            step_q   = {q[WIDTH-2:0], fill_l};
            step_out = q[WIDTH-1];
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: clr aborts everything, SHIFT runs until cnt reaches 1
    always_comb begin
        state_nxt = IDLE;
        if (!clr) begin
            case (state)
                SHIFT:   state_nxt = (cnt == CW'(1)) ? DONE : SHIFT;
                default: begin
                    if (accept) state_nxt = (eff == '0) ? DONE : SHIFT;
                    else        state_nxt = IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath: load, latch shift parameters, step and count down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            sout    <= 1'b0;
            cnt     <= '0;
            dir_r   <= 1'b0;
            arith_r <= 1'b0;
`ifdef SHIFT_RGST_ROTATE_EN
            rot_r   <= 1'b0;
`endif
        end else if (clr) begin
            q    <= '0;
            sout <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            q    <= step_q;
            sout <= step_out;
            cnt  <= cnt - CW'(1);
        end else if (ld) begin
            q <= d;
        end else if (start) begin
            dir_r   <= dir;
            arith_r <= arith;
`ifdef SHIFT_RGST_ROTATE_EN
            rot_r   <= rot;
`endif
            cnt     <= eff;
        end
    end

endmodule

// File: tb/tb_shift_rgst.sv
// tb_shift_rgst: directed test of shift_rgst (WIDTH=8). Each started shift
// pushes its expected result onto a queue; a monitor pops and checks on done.
module tb_shift_rgst;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             ld = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic             arith = 1'b0;
    logic             sin = 1'b0;
    logic [CW-1:0]    amt = '0;
    logic             rot = 1'b0;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             sout;
        int               nbusy;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   busy_cnt = 0;

    shift_rgst #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .start(start),
        .dir(dir), .arith(arith), .sin(sin), .amt(amt), .rot(rot),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] eq, input logic es, input int nb, input string nm);
        exp_t e;
        e.q = eq; e.sout = es; e.nbusy = nb; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic do_ld(input logic [WIDTH-1:0] v);
        ld = 1'b1; d = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic do_start(input logic sdir, input logic sar, input logic srot,
                            input logic ssin, input logic [CW-1:0] samt);
        dir = sdir; arith = sar; rot = srot; sin = ssin; amt = samt; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: count busy cycles, check result and busy length on each done
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_q"},    64'(q),        64'(e.q));
                chk({e.name, "_sout"}, 64'(sout),     64'(e.sout));
                chk({e.name, "_busy"}, 64'(busy_cnt), 64'(e.nbusy));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_q", 64'(q), 64'(0));
        chk("rst_sout", 64'(sout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // Parallel load, then clr beats a simultaneous load
        do_ld(8'hA5);
        chk("ld_q", 64'(q), 64'(8'hA5));
        clr = 1'b1; ld = 1'b1; d = 8'h3C;
        tick();
        clr = 1'b0; ld = 1'b0;
        chk("clr_over_ld_q", 64'(q), 64'(0));

        // Left shift by 3: 0x81 -> 0x02 -> 0x04 -> 0x08, last bit out 0
        do_ld(8'h81);
        push(8'h08, 1'b0, 3, "left3");
        do_start(1'b0, 1'b0, 1'b0, 1'b0, CW'(3));
        repeat (5) tick();

        // Arithmetic right by 2: 0x90 -> 0xC8 -> 0xE4
        do_ld(8'h90);
        push(8'hE4, 1'b0, 2, "asr2");
        do_start(1'b1, 1'b1, 1'b0, 1'b0, CW'(2));
        repeat (4) tick();

        // Zero amount: straight to DONE, q untouched
        push(8'hE4, 1'b0, 0, "amt0");
        do_start(1'b1, 1'b1, 1'b0, 1'b0, CW'(0));
        repeat (3) tick();

        // amt=12 clamps to 8 steps of sin=1; ld in SHIFT ignored; start in DONE taken
        do_ld(8'h00);
        push(8'hFF, 1'b0, 8, "clamp12");
        do_start(1'b0, 1'b0, 1'b0, 1'b1, CW'(12));
        ld = 1'b1; d = 8'h55;
        tick();
        ld = 1'b0;
        repeat (7) tick();
        // now in DONE: logical right by 1 of 0xFF with sin=0
        push(8'h7F, 1'b1, 1, "start_in_done");
        do_start(1'b1, 1'b0, 1'b0, 1'b0, CW'(1));
        repeat (4) tick();

        // clr on the 2nd SHIFT cycle aborts with no done
        do_ld(8'h0F);
        do_start(1'b0, 1'b0, 1'b0, 1'b0, CW'(5));
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_abort_q", 64'(q), 64'(0));
        chk("clr_abort_sout", 64'(sout), 64'(0));
        chk("clr_abort_busy", 64'(busy), 64'(0));
        chk("clr_abort_done", 64'(done), 64'(0));
        repeat (6) tick();

        // Asynchronous reset mid-shift: outputs clear without a clock edge
        do_ld(8'hF0);
        do_start(1'b0, 1'b0, 1'b0, 1'b1, CW'(4));
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_q", 64'(q), 64'(0));
        chk("arst_sout", 64'(sout), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        #1 rst = 1'b0;
        repeat (6) tick();

        // Rotate request: only honoured when the rotate feature is built in
        do_ld(8'h81);
`ifdef SHIFT_RGST_ROTATE_EN
        push(8'hC0, 1'b1, 1, "rotr1");
`else
        push(8'h40, 1'b1, 1, "rotr1_off");
`endif
        do_start(1'b1, 1'b0, 1'b1, 1'b0, CW'(1));
        repeat (4) tick();

        // Every expected completion must have been observed
        chk("pending_results", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
